word_byte_serializer: RTL
=========================

Name: word_byte_serializer

Overview:
- Reader side of the byte-replicating 56-bit word register: accepts one 56-bit word and emits its 7 bytes one per cycle on an 8-bit stream.
- Sits between a word producer (valid/ready) and the 8-bit output pad bus.
- Flags whether the word was a uniform (replicated-byte) pattern.
- Counts completed words for debug.

Parameters:
- BYTE_W, 8, bits per output byte.
- NUM_BYTES, 7, bytes per word; must be ≥2.
- MSB_FIRST, 0, 0 = emit byte 0 (bits BYTE_W-1:0) first; 1 = emit the top byte first.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_word  in  BYTE_W*NUM_BYTES  word to serialize.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  BYTE_W  current byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes the byte this cycle.
- out_last  out  1  current byte is the final byte of the word.
- out_idx  out  clog2(NUM_BYTES)  emission index of the current byte, 0-based.
- out_uniform  out  1  all bytes of the current word are equal.
- word_count  out  CNT_W  number of words fully emitted.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - out_valid=0, out_data=0, out_last=0, out_idx=0, out_uniform=0, word_count=0.
  - in_ready is forced to 0 while rst is high.
- States: IDLE and SEND.
- in_ready (combinational):
  - 1 in IDLE.
  - In SEND, 1 only when out_valid && out_ready && out_last (this allows back-to-back words).
  - 0 otherwise.
- Load: when in_valid && in_ready at a clock edge:
  - Capture in_word into the shift register and enter SEND.
  - Next cycle: out_valid=1, out_idx=0, out_data=first byte (per MSB_FIRST).
  - out_uniform is registered at load: 1 if every BYTE_W slice equals slice 0. It is held for the whole word.
  - Load-to-first-byte latency is 1 cycle.
- Stall: while out_valid && !out_ready, out_data, out_idx, out_last and out_uniform hold stable.
- Advance: on out_valid && out_ready with out_last=0:
  - out_idx increments.
  - out_data moves to the next byte (shift by BYTE_W).
- out_last is 1 exactly when out_idx == NUM_BYTES-1.
- Last-byte accept (out_valid && out_ready && out_last):
  - word_count increments; it wraps from all-ones to 0.
  - If in_valid is also high, the new word loads in the same edge. No bubble: the new byte 0 is presented the next cycle.
  - Otherwise return to IDLE and clear out_valid, out_last, out_idx and out_data to 0. out_uniform also clears to 0.
- Throughput: with out_ready held high, one byte per cycle and NUM_BYTES cycles per word.
- in_valid while SEND and not on the last-byte accept: ignored, no capture. The producer must hold the word.
- Reset mid-word: the partial word is discarded immediately and asynchronously, no byte is emitted after reset, and word_count is cleared.
- out_idx counter width is clog2(NUM_BYTES); its value never exceeds NUM_BYTES-1.

Test Plan:
- Reset, then in_word=56'h77665544332211 with in_valid pulsed and out_ready=1 -> from the next cycle out_data=11,22,33,44,55,66,77 on consecutive cycles, out_last only on 77, out_uniform=0, word_count=1, then out_valid=0 and in_ready=1.
- in_word=56'hA5A5A5A5A5A5A5 -> 7 bytes of A5, out_uniform=1 throughout. Then 56'hA5A5A5A5A5A5A4 -> out_uniform=0.
- Backpressure: out_ready low on idx 2 for 3 cycles -> out_data=33 and out_idx=2 held stable; the sequence resumes with 44 and no byte is lost or duplicated.
- Back-to-back: second word 56'h0E0D0C0B0A0908 presented with in_valid held high -> in_ready=1 only on the edge where 77 is accepted; 14 bytes are emitted in 14 consecutive cycles; word_count=2.
- Reset asserted mid-word after byte 33 -> out_valid=0 and out_data=0 immediately, word_count=0; after deassert, the next word starts at idx 0.
- MSB_FIRST=1 with 56'h77665544332211 -> order 77,66,...,11. CNT_W=2 with 5 words emitted -> word_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/word_byte_serializer_if.sv
// Word-in / byte-out stream bundle for word_byte_serializer.
// master drives the word and takes the bytes; slave is the serializer itself.
interface word_byte_serializer_if #(
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned NUM_BYTES = 7
);
  localparam int unsigned IdxW = $clog2(NUM_BYTES);

  logic [BYTE_W*NUM_BYTES-1:0] in_word;
  logic                        in_valid;
  logic                        in_ready;
  logic [BYTE_W-1:0]           out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic [IdxW-1:0]             out_idx;
  logic                        out_uniform;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_idx, out_uniform
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_idx, out_uniform
  );
endinterface

// File: rtl/word_byte_serializer.sv
// Accepts one NUM_BYTES-wide word and streams its bytes out one per cycle,
// flagging replicated-byte words and counting completed words.
module word_byte_serializer #(
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned NUM_BYTES = 7,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  word_byte_serializer_if.slave   bus,
  output logic [CNT_W-1:0]        word_count
);

  localparam int unsigned WordW = BYTE_W * NUM_BYTES;
  localparam int unsigned IdxW  = $clog2(NUM_BYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StSend = 1'b1;

  if (NUM_BYTES < 2) begin : g_bad_num_bytes
    $error("word_byte_serializer: NUM_BYTES must be at least 2");
  end

  logic             state_q, state_d;
  logic [WordW-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             uniform_q, uniform_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic out_valid;
  logic out_last;
  logic fire;
  logic fire_last;
  logic load;
  logic in_uniform;

  assign out_valid = (state_q == StSend);
  assign out_last  = out_valid && (idx_q == LastIdx);
  assign fire      = out_valid && bus.out_ready;
  assign fire_last = fire && out_last;

  // Accepting on the last-byte handshake lets a new word follow without a bubble.
  assign bus.in_ready = !rst && ((state_q == StIdle) || fire_last);
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    in_uniform = 1'b1;
    for (int unsigned i = 1; i < NUM_BYTES; i++) begin
      if (bus.in_word[i*BYTE_W +: BYTE_W] != bus.in_word[BYTE_W-1:0]) begin
        in_uniform = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    uniform_d = uniform_q;
    cnt_d     = cnt_q;

    if (fire_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load) begin
      state_d   = StSend;
      shreg_d   = bus.in_word;
      idx_d     = '0;
      uniform_d = in_uniform;
    end else if (fire_last) begin
      state_d   = StIdle;
      shreg_d   = '0;
      idx_d     = '0;
      uniform_d = 1'b0;
    end else if (fire) begin
      idx_d = idx_q + IdxW'(1);
      if (MSB_FIRST) begin
        shreg_d = shreg_q << BYTE_W;
      end else begin
        shreg_d = shreg_q >> BYTE_W;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      idx_q     <= '0;
      uniform_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      uniform_q <= uniform_d;
      cnt_q     <= cnt_d;
    end
  end

  // The shift register is zero outside SEND, so out_data reads 0 when idle.
  if (MSB_FIRST) begin : g_msb
    assign bus.out_data = shreg_q[WordW-1 -: BYTE_W];
  end else begin : g_lsb
    assign bus.out_data = shreg_q[BYTE_W-1:0];
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_last    = out_last;
  assign bus.out_idx     = idx_q;
  assign bus.out_uniform = uniform_q;
  assign word_count      = cnt_q;

endmodule
